// File: rtl/exp_op_sequencer.sv
// exp_op_sequencer: control FSM for the shared exponent adder/subtractor.
// Each FP add/sub uses the datapath for the alignment difference (with an
// optional swapped re-run) and then for the post-normalization adjustment.
// All outputs are registered. busy_o is decoded directly from the state.
module exp_op_sequencer #(
  parameter int EW = 8,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [EW-1:0] exp_a_i,
  input  logic [EW-1:0] exp_b_i,
  input  logic          norm_valid_i,
  input  logic          norm_carry_i,
  input  logic [SW-1:0] norm_shift_i,
  output logic          dp_load_o,
  output logic          dp_add_subt_o,
  output logic [EW-1:0] dp_a_o,
  output logic [EW-1:0] dp_b_o,
  input  logic [EW-1:0] dp_result_i,
  input  logic          dp_ovf_i,
  input  logic          dp_unf_i,
  output logic          busy_o,
  output logic          diff_valid_o,
  output logic [EW-1:0] diff_o,
  output logic          swap_o,
  output logic          done_o,
  output logic [EW-1:0] exp_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  typedef enum logic [3:0] {
    IDLE, DIFF, DIFF_WB, SWAP, SWAP_WB, WAIT_NORM, ADJ, ADJ_WB, DONE
  } state_t;

  state_t        state;
  logic [EW-1:0] ea_q;
  logic [EW-1:0] eb_q;
  logic [EW-1:0] emax_q;
  logic          swap_q;
  logic          ovf_q;
  logic          unf_q;
  logic [EW-1:0] adj_inc;
  logic [EW-1:0] adj_dif;
  logic          adj_ovf;
  logic          adj_unf;

  // Saturate the adjusted exponent: all-ones on overflow, zero on underflow.
  function automatic logic [EW-1:0] sat_exp(input logic ovf, input logic unf,
                                            input logic [EW-1:0] res);
    if (ovf)      sat_exp = '1;
    else if (unf) sat_exp = '0;
    else          sat_exp = res;
  endfunction

  // Overflow also covers landing on the all-ones (reserved) exponent;
  // underflow also covers an exact zero result.
  assign adj_inc = dp_a_o + EW'(1);
  assign adj_dif = dp_a_o - dp_b_o;
  assign adj_ovf = dp_ovf_i | (~dp_add_subt_o & (adj_inc == '1));
  assign adj_unf = dp_unf_i | (dp_add_subt_o & (adj_dif == '0));

  assign busy_o = (state != IDLE);

  // Sequencer state, datapath command registers and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ea_q          <= '0;
      eb_q          <= '0;
      emax_q        <= '0;
      swap_q        <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      dp_load_o     <= 1'b0;
      dp_add_subt_o <= 1'b0;
      dp_a_o        <= '0;
      dp_b_o        <= '0;
      diff_valid_o  <= 1'b0;
      diff_o        <= '0;
      swap_o        <= 1'b0;
      done_o        <= 1'b0;
      exp_o         <= '0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      dp_load_o     <= 1'b0;
      dp_add_subt_o <= 1'b0;
      dp_a_o        <= '0;
      dp_b_o        <= '0;
      diff_valid_o  <= 1'b0;
      done_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            ea_q          <= exp_a_i;
            eb_q          <= exp_b_i;
            overflow_o    <= 1'b0;
            underflow_o   <= 1'b0;
            dp_load_o     <= 1'b1;
            dp_add_subt_o <= 1'b1;
            dp_a_o        <= exp_a_i;
            dp_b_o        <= exp_b_i;
            state         <= DIFF;
          end
        end
        DIFF: begin
          swap_q <= dp_unf_i;
          state  <= DIFF_WB;
        end
        DIFF_WB: begin
          if (swap_q) begin
            dp_load_o     <= 1'b1;
            dp_add_subt_o <= 1'b1;
            dp_a_o        <= eb_q;
            dp_b_o        <= ea_q;
            state         <= SWAP;
          end else begin
            diff_o       <= dp_result_i;
            emax_q       <= ea_q;
            swap_o       <= 1'b0;
            diff_valid_o <= 1'b1;
            state        <= WAIT_NORM;
          end
        end
        SWAP: state <= SWAP_WB;
        SWAP_WB: begin
          diff_o       <= dp_result_i;
          emax_q       <= eb_q;
          swap_o       <= 1'b1;
          diff_valid_o <= 1'b1;
          state        <= WAIT_NORM;
        end
        WAIT_NORM: begin
          if (norm_valid_i) begin
            if (norm_carry_i) begin
              dp_load_o <= 1'b1;
              dp_a_o    <= emax_q;
              dp_b_o    <= EW'(1);
              state     <= ADJ;
            end else if (norm_shift_i != '0) begin
              dp_load_o     <= 1'b1;
              dp_add_subt_o <= 1'b1;
              dp_a_o        <= emax_q;
              dp_b_o        <= EW'(norm_shift_i);
              state         <= ADJ;
            end else begin
              exp_o  <= emax_q;
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        ADJ: begin
          ovf_q <= adj_ovf;
          unf_q <= adj_unf;
          state <= ADJ_WB;
        end
        ADJ_WB: begin
          exp_o       <= sat_exp(ovf_q, unf_q, dp_result_i);
          overflow_o  <= ovf_q;
          underflow_o <= ~ovf_q & unf_q;
          done_o      <= 1'b1;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
